// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution window sequencer:
// FSM state encoding, kernel geometry and the column-fetch length.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EVAL  = 2'd2,
        DONE  = 2'd3
    } conv_state_e;

    localparam int K         = 3;
    localparam int WIN_N     = K * K;
    localparam int FETCH_CYC = 4;

endpackage

// File: rtl/conv_addr_gen.sv
// Row/column/phase counters of the window walk plus the pixel read and
// result write address generators, driven by the latched bases and width.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic              fetch,
    input  logic              next_row,
    input  logic [DIM_W-1:0]  img_w,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic [1:0]        k,
    output logic [DIM_W-1:0]  x,
    output logic [DIM_W-1:0]  r,
    output logic [DIM_W-1:0]  w,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr
);

    logic [ADDR_W-1:0] in_base_q;
    logic [ADDR_W-1:0] out_base_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            x          <= '0;
            r          <= '0;
            w          <= '0;
            in_base_q  <= '0;
            out_base_q <= '0;
        end else if (init) begin
            w          <= img_w;
            in_base_q  <= in_base;
            out_base_q <= out_base;
            r          <= '0;
            x          <= '0;
            k          <= '0;
        end else if (fetch) begin
            if (k == 2'(FETCH_CYC - 1)) begin
                k <= '0;
                x <= x + 1'b1;
            end else begin
                k <= k + 1'b1;
            end
        end else if (next_row) begin
            r <= r + 1'b1;
            x <= '0;
        end
    end

    // Computing directly at ADDR_W bits yields the low bits of the full
    // product, i.e. the intended wrap modulo 2^ADDR_W.
    always_comb begin
        rd_addr = in_base_q + (ADDR_W'(r) + ADDR_W'(k)) * ADDR_W'(w) + ADDR_W'(x);
        wr_addr = out_base_q + ADDR_W'(r) * (ADDR_W'(w) - ADDR_W'(K - 1))
                + ADDR_W'(x) - ADDR_W'(K);
    end

endmodule

// File: rtl/conv_window_seq.sv
// Raster-order 3x3 window sequencer between pixel RAM and the conv unit.
// Define CONV_SEQ_RELU_EN to clamp negative results to zero on write-back.
module conv_window_seq
    import conv_pkg::*;
#(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 12,
    parameter int DIM_W  = 6
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [DIM_W-1:0]       img_w,
    input  logic [DIM_W-1:0]       img_h,
    input  logic [ADDR_W-1:0]      in_base,
    input  logic [ADDR_W-1:0]      out_base,
    output logic                   busy,
    output logic                   done,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [WIDTH-1:0]       rd_data,
    output logic [WIN_N*WIDTH-1:0] win,
    output logic                   win_valid,
    input  logic [WIDTH-1:0]       conv_out,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [WIDTH-1:0]       wr_data
);

    conv_state_e       state;
    logic [DIM_W-1:0]  h_q;
    logic [1:0]        need;
    logic [WIDTH-1:0]  stage [2];
    logic [WIDTH-1:0]  new_col [K];
    logic [WIDTH-1:0]  result;

    logic [1:0]        k;
    logic [DIM_W-1:0]  x;
    logic [DIM_W-1:0]  r;
    logic [DIM_W-1:0]  w;
    logic [ADDR_W-1:0] ag_rd_addr;
    logic [ADDR_W-1:0] ag_wr_addr;
    logic              ag_init;
    logic              ag_fetch;
    logic              ag_next_row;
    logic              col_last;
    logic              x_more;
    logic              row_more;

    assign col_last    = (k == 2'(FETCH_CYC - 1));
    assign x_more      = (x < w);
    assign row_more    = (({1'b0, r} + (DIM_W + 1)'(K)) < {1'b0, h_q});
    assign ag_init     = (state == IDLE) && start;
    assign ag_fetch    = (state == FETCH);
    assign ag_next_row = (state == EVAL) && !x_more && row_more;

    conv_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (ag_init),
        .fetch    (ag_fetch),
        .next_row (ag_next_row),
        .img_w    (img_w),
        .in_base  (in_base),
        .out_base (out_base),
        .k        (k),
        .x        (x),
        .r        (r),
        .w        (w),
        .rd_addr  (ag_rd_addr),
        .wr_addr  (ag_wr_addr)
    );

    // The bottom pixel of a column arrives in the same cycle the window
    // shifts, so it bypasses staging.
    assign new_col[0] = stage[0];
    assign new_col[1] = stage[1];
    assign new_col[2] = rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            h_q      <= '0;
            need     <= '0;
            stage[0] <= '0;
            stage[1] <= '0;
            win      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        h_q <= img_h;
                        if (img_w < DIM_W'(K) || img_h < DIM_W'(K)) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                            need  <= 2'(K);
                        end
                    end
                end
                FETCH: begin
                    if (k == 2'd1) stage[0] <= rd_data;
                    if (k == 2'd2) stage[1] <= rd_data;
                    if (col_last) begin
                        for (int i = 0; i < K; i++) begin
                            win[(K*i)*WIDTH +: WIDTH]   <= win[(K*i+1)*WIDTH +: WIDTH];
                            win[(K*i+1)*WIDTH +: WIDTH] <= win[(K*i+2)*WIDTH +: WIDTH];
                            win[(K*i+2)*WIDTH +: WIDTH] <= new_col[i];
                        end
                        need <= need - 2'd1;
                        if (need == 2'd1) state <= EVAL;
                    end
                end
                EVAL: begin
                    if (x_more) begin
                        need  <= 2'd1;
                        state <= FETCH;
                    end else if (row_more) begin
                        need  <= 2'(K);
                        state <= FETCH;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_RELU_EN
    assign result = conv_out[WIDTH-1] ? '0 : conv_out;
`else
    assign result = conv_out;
`endif

    assign busy      = (state == FETCH) || (state == EVAL);
    assign done      = (state == DONE);
    assign rd_en     = (state == FETCH) && !col_last;
    assign rd_addr   = rd_en ? ag_rd_addr : '0;
    assign win_valid = (state == EVAL);
    assign wr_en     = (state == EVAL);
    assign wr_addr   = wr_en ? ag_wr_addr : '0;
    assign wr_data   = wr_en ? result : '0;

endmodule

// File: tb/tb_conv_window_seq.sv
// Scoreboard bench for conv_window_seq: a per-frame reference model fills an
// expected queue (rel cycle, address, data) that a negedge monitor consumes.
module tb_conv_window_seq;

    localparam int EXP_W = 37;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  img_w = '0;
    logic [5:0]  img_h = '0;
    logic [11:0] in_base = '0;
    logic [11:0] out_base = '0;
    logic        busy;
    logic        done;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [8:0]  rd_data = '0;
    logic [80:0] win;
    logic        win_valid;
    logic [8:0]  conv_out;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [8:0]  wr_data;

    logic [8:0]       mem [4096];
    logic [EXP_W-1:0] exp_q [$];
    int  conv_mode = 0;
    int  checks = 0;
    int  errors = 0;
    int  rd_cnt = 0;
    int  wr_cnt = 0;
    int  busy_cnt = 0;
    int  done_cnt = 0;
    int  done_rel = 0;
    time t_start = 0;

    conv_window_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_w     (img_w),
        .img_h     (img_h),
        .in_base   (in_base),
        .out_base  (out_base),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .win       (win),
        .win_valid (win_valid),
        .conv_out  (conv_out),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // ---------------- clock / memory / conv stand-in ----------------
    always #5 clk = ~clk;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    function automatic logic [8:0] conv_model(input logic [80:0] wv, input int mode);
        int acc;
        acc = 0;
        if (mode == 2) return 9'h1F0;
        for (int i = 0; i < 9; i++)
            acc += int'(wv[i*9 +: 9]) * ((mode == 1) ? (i + 1) : 1);
        return acc[8:0];
    endfunction

    assign conv_out = conv_model(win, conv_mode);

    function automatic logic [8:0] relu_ref(input logic [8:0] d);
`ifdef CONV_SEQ_RELU_EN
        return d[8] ? 9'd0 : d;
`else
        return d;
`endif
    endfunction

    function automatic int rel_now();
        return int'(($time - t_start + 5) / 10);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n) begin
            if (rd_en) rd_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_rel = rel_now();
            end
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none", wr_addr, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_rel", 64'(rel_now()), 64'(e[36:21]));
                    check("wr_addr", 64'(wr_addr), 64'(e[20:9]));
                    check("wr_data", 64'(wr_data), 64'(e[8:0]));
                    check("win_valid", 64'(win_valid), 64'd1);
                end
            end
        end
    end

    // ---------------- reference model + drivers ----------------
    int exp_done_rel, exp_rd, exp_wr;

    task automatic fill_image(input int w, input int h, input int ib, input bit ramp);
        for (int y = 0; y < h; y++)
            for (int xx = 0; xx < w; xx++)
                mem[(ib + y * w + xx) % 4096] = ramp ? 9'(y * w + xx) : 9'($urandom_range(0, 511));
    endtask

    // Every valid output position in raster order: 13 cycles to the first
    // result of a row (three full columns), 5 per additional column.
    task automatic build_model(input int w, input int h, input int ib, input int ob, input int mode);
        int t, acc, addr;
        logic [8:0] d;
        t = 0;
        exp_wr = 0;
        if (w >= 3 && h >= 3) begin
            for (int r = 0; r <= h - 3; r++) begin
                for (int c = 0; c <= w - 3; c++) begin
                    t += (c == 0) ? 13 : 5;
                    acc = 0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            acc += int'(mem[(ib + (r + i) * w + c + j) % 4096]) * ((mode == 1) ? (3 * i + j + 1) : 1);
                    d = (mode == 2) ? 9'h1F0 : acc[8:0];
                    addr = (ob + r * (w - 2) + c) % 4096;
                    exp_q.push_back({16'(t), 12'(addr), relu_ref(d)});
                    exp_wr++;
                end
            end
            exp_rd = (h - 2) * w * 3;
        end else begin
            exp_rd = 0;
        end
        exp_done_rel = t + 1;
    endtask

    task automatic start_frame(input int w, input int h, input int ib, input int ob);
        @(negedge clk); #1;
        img_w = 6'(w);
        img_h = 6'(h);
        in_base = 12'(ib);
        out_base = 12'(ob);
        rd_cnt = 0;
        wr_cnt = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_rel = 0;
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int glitch_rel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
            if (glitch_rel > 0 && rel_now() == glitch_rel) begin
                start = 1'b1;
                img_w = 6'd3;
                img_h = 6'd3;
                in_base = 12'h300;
                out_base = 12'h700;
            end else if (start) begin
                start = 1'b0;
            end
        end
        check("done_seen", 64'(ok), 64'd1);
    endtask

    task automatic run_frame(input int w, input int h, input int ib, input int ob,
                             input int mode, input int glitch, input bit ramp);
        fill_image(w, h, ib, ramp);
        conv_mode = mode;
        build_model(w, h, ib, ob, mode);
        start_frame(w, h, ib, ob);
        wait_done(3000, glitch);
        repeat (3) @(negedge clk);
        #1;
        check("done_rel", 64'(done_rel), 64'(exp_done_rel));
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_cycles", 64'(busy_cnt), 64'(exp_done_rel - 1));
        check("rd_count", 64'(rd_cnt), 64'(exp_rd));
        check("wr_count", 64'(wr_cnt), 64'(exp_wr));
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
        check({tag, "_win_valid"}, 64'(win_valid), 64'd0);
        check({tag, "_wr_en"}, 64'(wr_en), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data), 64'd0);
        check({tag, "_win_nonzero"}, 64'(|win), 64'd0);
    endtask

    // ---------------- main sequence + final report ----------------
    initial begin
        #12;
        check_all_zero("reset");
        @(negedge clk); #1;
        rst_n = 1'b1;

        // 4x4 ramp, plain sum: 45, 54, 81, 90 at 0x100..0x103
        run_frame(4, 4, 0, 'h100, 0, 0, 1'b1);
        // degenerate width: no traffic, done right away
        run_frame(2, 5, 'h040, 'h200, 1, 0, 1'b0);
        // 5x3: three writes at 13/18/23, 15 reads
        run_frame(5, 3, 'h080, 'h300, 1, 0, 1'b0);
        // start re-pulsed mid-frame must change nothing
        run_frame(5, 5, 'h0C0, 'h400, 1, 20, 1'b0);
        // address wrap on both read and write side
        run_frame(7, 4, 'hFF0, 'hFFE, 1, 0, 1'b0);
        // negative result: clamped only with the ReLU build
        run_frame(3, 3, 'h500, 'h600, 2, 0, 1'b0);

        for (int n = 0; n < 4; n++)
            run_frame($urandom_range(3, 8), $urandom_range(3, 5),
                      $urandom_range(0, 4095), $urandom_range(0, 4095), 1, 0, 1'b0);

        // reset during the second FETCH of the 4x4 frame
        fill_image(4, 4, 0, 1'b1);
        conv_mode = 0;
        build_model(4, 4, 0, 'h100, 0);
        start_frame(4, 4, 0, 'h100);
        for (int i = 0; i < 40 && rel_now() < 15; i++) begin
            @(negedge clk); #1;
        end
        check("pre_reset_rd_en", 64'(rd_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("post_reset_wr_count", 64'(wr_cnt), 64'd1);
        check("post_reset_idle", 64'(busy), 64'd0);
        run_frame(4, 4, 0, 'h100, 0, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
